nand_target: RTL and testbench

//  Synthesizable NAND flash device model: the responder end of the NAND pin interface driven by the controller FSM.

---
 rtl/nand_target.sv | 240 ++++++++++++++++++++++++
 tb/tb_nand_target.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nand_target.sv
// NAND flash responder: oversamples the async NAND strobes on P_clk, decodes the
// reset/read/program/erase/status command set and serves a small page array.
module nand_target #(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 8,
  parameter int T_R        = 20,
  parameter int T_PROG     = 40,
  parameter int T_ERASE    = 60,
  parameter int T_RST      = 8
) (
  input  logic       P_clk,
  input  logic       P_rst,
  input  logic       F_nCE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_nWE,
  input  logic       F_nRE,
  input  logic       F_nWP,
  input  logic [7:0] F_DIO_in,
  output logic [7:0] F_DIO_out,
  output logic       F_DIO_oe,
  output logic       F_nRB
);

  localparam int CW    = $clog2(PAGE_BYTES);
  localparam int PW    = $clog2(NUM_PAGES);
  localparam int AW    = CW + PW;
  localparam int MEM_N = PAGE_BYTES * NUM_PAGES;

  typedef struct packed {
    logic nce;
    logic cle;
    logic ale;
    logic nwe;
    logic nre;
    logic nwp;
  } pins_t;

  localparam pins_t PINS_IDLE = '{nce: 1'b1, cle: 1'b0, ale: 1'b0,
                                  nwe: 1'b1, nre: 1'b1, nwp: 1'b1};

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_RADDR, S_PADDR, S_RCONF,
    S_DIN, S_EADDR, S_ECONF, S_BUSY, S_DOUT
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_RST} op_t;

  // two-flop synchronisers; a third flop on the strobes gives edge detect
  pins_t      p1, p2;
  logic       we3, re3;
  logic [7:0] d1, d2;

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      p1  <= PINS_IDLE;
      p2  <= PINS_IDLE;
      we3 <= 1'b1;
      re3 <= 1'b1;
      d1  <= '0;
      d2  <= '0;
    end else begin
      p1  <= '{F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP};
      p2  <= p1;
      we3 <= p2.nwe;
      re3 <= p2.nre;
      d1  <= F_DIO_in;
      d2  <= d1;
    end
  end

  logic we_rise, re_fall, re_rise, cmd_ev, adr_ev, dat_ev;
  assign we_rise = ~p2.nce & p2.nwe & ~we3;
  assign re_fall = ~p2.nce & ~p2.nre & re3 & ~we_rise;
  assign re_rise = ~p2.nce & p2.nre & ~re3 & ~we_rise;
  assign cmd_ev  = we_rise & p2.cle & ~p2.ale;
  assign adr_ev  = we_rise & p2.ale & ~p2.cle;
  assign dat_ev  = we_rise & ~p2.ale & ~p2.cle;

  state_t                       state, state_n;
  op_t                          op, busy_op;
  logic [7:0]                   mem [MEM_N];
  logic [PAGE_BYTES-1:0][7:0]   page_buf;
  logic [CW-1:0]                col, col0;
  logic [PW-1:0]                page;
  logic [2:0]                   acnt;
  logic [AW-1:0]                init_idx;
  logic [CW:0]                  bidx;
  logic [15:0]                  cnt, busy_len;
  logic                         fail, prot, stat, oe_r;
  logic [7:0]                   dout;
  logic                         busy_go, stat_on, stat_off, buf_ff, addr_clr;
  logic                         addr_st, mem_we, copy_en;
  logic [AW-1:0]                mem_a;
  logic [7:0]                   mem_d, status;

  assign F_nRB     = ~(state == S_INIT || state == S_BUSY);
  assign F_DIO_oe  = oe_r & ~p2.nce;
  assign F_DIO_out = dout;
  assign status    = {p2.nwp, F_nRB, 5'b0, fail};
  assign addr_st   = (state == S_RADDR) || (state == S_PADDR) || (state == S_EADDR);

  always_comb begin
    state_n  = state;
    busy_go  = 1'b0;
    busy_op  = OP_RST;
    stat_on  = 1'b0;
    stat_off = 1'b0;
    buf_ff   = 1'b0;
    addr_clr = 1'b0;
    case (state)
      S_INIT:  if (&init_idx) state_n = S_IDLE;
      S_BUSY:  if (cnt == '0) state_n = (op == OP_READ) ? S_DOUT : S_IDLE;
      default: ;
    endcase
    if (state != S_INIT && cmd_ev) begin
      if (d2 == 8'hFF) begin
        busy_go  = 1'b1;
        busy_op  = OP_RST;
        stat_off = 1'b1;
        state_n  = S_BUSY;
      end else if (d2 == 8'h70) begin
        stat_on = 1'b1;
        if (state == S_DOUT) state_n = S_IDLE;
      end else if (state != S_BUSY) begin
        // anything not matching the current sequence drops back to idle
        stat_off = 1'b1;
        addr_clr = 1'b1;
        state_n  = S_IDLE;
        case (state)
          S_IDLE, S_DOUT:
            case (d2)
              8'h00:   state_n = S_RADDR;
              8'h80:   begin state_n = S_PADDR; buf_ff = 1'b1; end
              8'h60:   state_n = S_EADDR;
              default: ;
            endcase
          S_RCONF: if (d2 == 8'h30) begin busy_go = 1'b1; busy_op = OP_READ;  state_n = S_BUSY; end
          S_DIN:   if (d2 == 8'h10) begin busy_go = 1'b1; busy_op = OP_PROG;  state_n = S_BUSY; end
          S_ECONF: if (d2 == 8'hD0) begin busy_go = 1'b1; busy_op = OP_ERASE; state_n = S_BUSY; end
          default: ;
        endcase
      end
    end else if (adr_ev) begin
      case (state)
        S_RADDR:                 if (acnt == 3'd4) state_n = S_RCONF;
        S_PADDR:                 if (acnt == 3'd4) state_n = S_DIN;
        S_EADDR:                 if (acnt == 3'd2) state_n = S_ECONF;
        S_RCONF, S_DIN, S_ECONF: state_n = S_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_len = 16'(T_RST - 1);
    case (busy_op)
      OP_READ:  busy_len = 16'(T_R - 1);
      OP_PROG:  busy_len = 16'(T_PROG - 1);
      OP_ERASE: busy_len = 16'(T_ERASE - 1);
      default:  ;
    endcase
  end

  // one array byte per cycle: init fill, or the busy-phase page copy
  assign copy_en = (state == S_BUSY) && !busy_go && !bidx[CW];
  assign mem_we  = (state == S_INIT) ||
                   (copy_en && !prot && (op == OP_PROG || op == OP_ERASE));
  assign mem_a   = (state == S_INIT) ? init_idx : {page, bidx[CW-1:0]};
  assign mem_d   = (state == S_INIT || op != OP_PROG) ? 8'hFF : page_buf[bidx[CW-1:0]];

  always_ff @(posedge P_clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state    <= S_INIT;
      op       <= OP_RST;
      page_buf <= '1;
      col      <= '0;
      col0     <= '0;
      page     <= '0;
      acnt     <= '0;
      init_idx <= '0;
      bidx     <= '0;
      cnt      <= '0;
      fail     <= 1'b0;
      prot     <= 1'b0;
      stat     <= 1'b0;
      oe_r     <= 1'b0;
      dout     <= '0;
    end else begin
      state <= state_n;
      if (state == S_INIT) init_idx <= init_idx + AW'(1);
      if (stat_on) stat <= 1'b1;
      else if (stat_off) stat <= 1'b0;
      if (buf_ff) page_buf <= '1;
      if (addr_clr) acnt <= '0;
      if (adr_ev && addr_st) begin
        acnt <= acnt + 3'd1;
        if (state != S_EADDR && acnt == 3'd0) begin
          col  <= d2[CW-1:0];
          col0 <= d2[CW-1:0];
        end
        if ((state != S_EADDR && acnt == 3'd2) || (state == S_EADDR && acnt == 3'd0))
          page <= d2[PW-1:0];
      end
      if (dat_ev && state == S_DIN) begin
        page_buf[col] <= d2;
        col           <= col + CW'(1);
      end
      if (busy_go) begin
        op   <= busy_op;
        cnt  <= busy_len;
        bidx <= '0;
        prot <= 1'b0;
        if (busy_op == OP_PROG || busy_op == OP_ERASE) begin
          prot <= ~p2.nwp;
          fail <= ~p2.nwp;
        end
      end else if (state == S_BUSY) begin
        cnt <= cnt - 16'd1;
        if (!bidx[CW]) bidx <= bidx + (CW+1)'(1);
        if (copy_en && op == OP_READ) page_buf[bidx[CW-1:0]] <= mem[{page, bidx[CW-1:0]}];
        if (cnt == '0 && op == OP_READ) col <= col0;
      end
      if (p2.nce) begin
        oe_r <= 1'b0;
      end else if (re_fall && (stat || state == S_DOUT)) begin
        oe_r <= 1'b1;
        dout <= stat ? status : page_buf[col];
      end else if (re_rise) begin
        oe_r <= 1'b0;
        if (!stat && state == S_DOUT) col <= col + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nand_target.sv
// Directed bench for nand_target: drives NAND pin cycles and checks array contents,
// busy lengths and status bytes against hand-computed values.
module tb_nand_target;
  logic       P_clk = 1'b0, P_rst = 1'b1;
  logic       F_nCE = 1'b0, F_CLE = 1'b0, F_ALE = 1'b0;
  logic       F_nWE = 1'b1, F_nRE = 1'b1, F_nWP = 1'b1;
  logic [7:0] F_DIO_in = 8'h00;
  logic [7:0] F_DIO_out;
  logic       F_DIO_oe, F_nRB;

  nand_target dut (
    .P_clk(P_clk), .P_rst(P_rst), .F_nCE(F_nCE), .F_CLE(F_CLE), .F_ALE(F_ALE),
    .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP), .F_DIO_in(F_DIO_in),
    .F_DIO_out(F_DIO_out), .F_DIO_oe(F_DIO_oe), .F_nRB(F_nRB)
  );

  always #5 P_clk = ~P_clk;

  int errors = 0, checks = 0, hold = 4, lowcnt = 0, last_low = 0;

  // length of the most recent busy (nRB low) interval, in clocks
  always @(negedge P_clk) begin
    if (F_nRB === 1'b0) lowcnt++;
    else if (F_nRB === 1'b1 && lowcnt != 0) begin
      last_low = lowcnt;
      lowcnt   = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
    F_CLE = cle; F_ALE = ale; F_DIO_in = d; F_nWE = 1'b0;
    repeat (hold) @(posedge P_clk);
    #1 F_nWE = 1'b1;
    repeat (hold) @(posedge P_clk);
    #1 F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c); wr(1'b1, 1'b0, c); endtask
  task automatic adr(input logic [7:0] a); wr(1'b0, 1'b1, a); endtask
  task automatic dat(input logic [7:0] d); wr(1'b0, 1'b0, d); endtask

  task automatic addr5(input logic [7:0] col, input logic [7:0] pg);
    adr(col); adr(8'h00); adr(pg); adr(8'h00); adr(8'h00);
  endtask

  task automatic wait_ready(input string tag, input int exp_len);
    int n = 0;
    while (!(F_nRB === 1'b1 && lowcnt == 0) && n < 5000) begin
      @(negedge P_clk); #1; n++;
    end
    chk({tag, " ready"}, F_nRB, 1);
    chk({tag, " busy_len"}, last_low, exp_len);
    @(posedge P_clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    logic       o;
    F_nRE = 1'b0;
    repeat (4) @(posedge P_clk);
    #1 v = F_DIO_out; o = F_DIO_oe;
    F_nRE = 1'b1;
    repeat (4) @(posedge P_clk);
    #1;
    chk({tag, " data"}, v, exp);
    chk({tag, " oe"}, o, 1);
  endtask

  task automatic read_page(input logic [7:0] pg, input logic [7:0] col);
    cmd(8'h00); addr5(col, pg); cmd(8'h30);
    wait_ready("read", 20);
  endtask

  logic [7:0] exp2 [5];
  logic [7:0] exp3 [4];

  initial begin
    exp2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hFF};
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44};

    // 1: reset and init fill
    @(posedge P_clk); #1;
    chk("rst nRB", F_nRB, 0);
    chk("rst oe", F_DIO_oe, 0);
    chk("rst dout", F_DIO_out, 0);
    P_rst = 1'b0;
    wait_ready("init", 128);
    read_page(8'd3, 8'd0);
    for (int i = 0; i < 16; i++) rd_chk("t1 page3", 8'hFF);
    chk("t1 oe after rise", F_DIO_oe, 0);

    // 2: program page 2 col 5
    cmd(8'h80); addr5(8'd5, 8'd2);
    dat(8'hA0); dat(8'hA1); dat(8'hA2); dat(8'hA3);
    cmd(8'h10);
    wait_ready("t2 prog", 40);
    read_page(8'd2, 8'd5);
    for (int i = 0; i < 5; i++) rd_chk("t2 page2", exp2[i]);

    // 3: column wrap on program and on read
    cmd(8'h80); addr5(8'd14, 8'd4);
    for (int i = 0; i < 4; i++) dat(exp3[i]);
    cmd(8'h10);
    wait_ready("t3 prog", 40);
    read_page(8'd4, 8'd14);
    for (int i = 0; i < 4; i++) rd_chk("t3 wrap", exp3[i]);

    // 4: erase page 2, neighbours untouched
    cmd(8'h60); adr(8'd2); adr(8'h00); adr(8'h00); cmd(8'hD0);
    wait_ready("t4 erase", 60);
    read_page(8'd2, 8'd0);
    for (int i = 0; i < 16; i++) rd_chk("t4 page2", 8'hFF);
    read_page(8'd3, 8'd0);
    rd_chk("t4 page3", 8'hFF);
    read_page(8'd4, 8'd14);
    rd_chk("t4 page4", 8'h11);

    // 5: write protect
    F_nWP = 1'b0;
    cmd(8'h80); addr5(8'd0, 8'd1); dat(8'h55); cmd(8'h10);
    wait_ready("t5 prog", 40);
    cmd(8'h70);
    rd_chk("t5 status", 8'h41);
    F_nWP = 1'b1;
    read_page(8'd1, 8'd0);
    rd_chk("t5 page1", 8'hFF);
    cmd(8'h60); adr(8'd6); adr(8'h00); adr(8'h00); cmd(8'hD0);
    wait_ready("t5 erase", 60);
    cmd(8'h70);
    rd_chk("t5 status clr", 8'hC0);

    // 6: 0xFF abort during program data phase, status while busy
    cmd(8'h80); addr5(8'd0, 8'd1); dat(8'h99);
    hold = 2;
    cmd(8'hFF);
    cmd(8'h70);
    rd_chk("t6 status busy", 8'h80);
    hold = 4;
    wait_ready("t6 abort", 8);
    read_page(8'd1, 8'd0);
    rd_chk("t6 page1", 8'hFF);

    // wrong confirm returns to idle; a late 0x30 must not start a read
    cmd(8'h00); addr5(8'd0, 8'd2); cmd(8'h10); cmd(8'h30);
    repeat (4) @(posedge P_clk); #1;
    chk("bad confirm nRB", F_nRB, 1);

    // bus not driven while chip deselected
    cmd(8'h70);
    F_nCE = 1'b1; F_nRE = 1'b0;
    repeat (4) @(posedge P_clk); #1;
    chk("nCE oe", F_DIO_oe, 0);
    F_nRE = 1'b1;
    repeat (4) @(posedge P_clk); #1;
    F_nCE = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
